// File: rtl/p_dec2to4_buf.sv
// Buffered 2-to-4 decoder: binary codes are queued in a DEPTH-entry FIFO, and the head entry is presented one-hot.
// Optional build macro: P_DEC_STICKY_EN adds a sticky OR of every popped one-hot word.
module p_dec2to4_buf #(
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [1:0]                   A,
   input  logic                         flush,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [3:0]                   Y,
   output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef P_DEC_STICKY_EN
   ,
   input  logic                         sticky_clr,
   output logic [3:0]                   sticky
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [1:0]    mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          full, push, pop;

   assign full      = (count_q == CW'(DEPTH));
   // Reset is folded in so that the producer sees not-ready while the block is held in reset.
   assign in_ready  = rst_n & ~full & ~flush;
   assign out_valid = (count_q != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready & ~flush;
   assign count     = count_q;
   assign Y         = out_valid ? (4'b0001 << mem_q[rd_ptr_q]) : 4'b0000;

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= 2'b00;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (push) mem_q[wr_ptr_q] <= A;
      end
   end

`ifdef P_DEC_STICKY_EN
   logic [3:0] sticky_q, sticky_d;

   always_comb begin
      sticky_d = sticky_q;
      if (sticky_clr)  sticky_d = 4'b0000;
      else if (pop)    sticky_d = sticky_q | Y;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sticky_q <= 4'b0000;
      else        sticky_q <= sticky_d;
   end

   assign sticky = sticky_q;
`endif

endmodule

// File: tb/tb_p_dec2to4_buf.sv
// Directed bench for p_dec2to4_buf (DEPTH=2): reset, fill/drain, streaming, random stalls against a queue model, flush, and async reset.
module tb_p_dec2to4_buf;

   localparam int DEPTH = 2;
   localparam int CW    = $clog2(DEPTH+1);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [1:0]    A;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [3:0]    Y;
   logic [CW-1:0] count;
`ifdef P_DEC_STICKY_EN
   logic          sticky_clr;
   logic [3:0]    sticky;
`endif

   int total = 0;
   int bad   = 0;

   p_dec2to4_buf #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Y         (Y),
      .count     (count)
`ifdef P_DEC_STICKY_EN
      ,
      .sticky_clr(sticky_clr),
      .sticky    (sticky)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk_state(input string tag, input logic ov, input logic [3:0] y, input int cnt);
      chk({tag, ".out_valid"}, {7'd0, out_valid}, {7'd0, ov});
      chk({tag, ".Y"}, {4'd0, Y}, {4'd0, y});
      chk({tag, ".count"}, 8'(count), 8'(cnt));
   endtask

   logic [1:0] model_q[$];
   logic [1:0] code3 [5] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
   logic [3:0] onehot3 [5] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};

   initial begin
      logic [3:0] exp_y;
      logic       exp_rdy, do_push, do_pop;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      A         = 2'd0;
      flush     = 1'b0;
      out_ready = 1'b0;
`ifdef P_DEC_STICKY_EN
      sticky_clr = 1'b0;
`endif
      repeat (3) tick();
      chk("rst.in_ready", {7'd0, in_ready}, 8'd0);
      chk_state("rst", 1'b0, 4'b0000, 0);
      rst_n = 1'b1;
      tick();
      // 1: idle after reset
      chk_state("idle", 1'b0, 4'b0000, 0);
      chk("idle.in_ready", {7'd0, in_ready}, 8'd1);

      // 2: over-fill with consumer stalled, then drain
      in_valid = 1'b1; A = 2'd0; tick();
      chk_state("fill1", 1'b1, 4'b0001, 1);
      A = 2'd1; tick();
      chk_state("fill2", 1'b1, 4'b0001, 2);
      chk("full.in_ready", {7'd0, in_ready}, 8'd0);
      A = 2'd2; tick();
      A = 2'd3; tick();
      chk_state("blocked", 1'b1, 4'b0001, 2);
      in_valid = 1'b0; out_ready = 1'b1; #1;
      chk("drain0.Y", {4'd0, Y}, 8'b0001);
      tick();
      chk_state("drain1", 1'b1, 4'b0010, 1);
      tick();
      chk_state("drain2", 1'b0, 4'b0000, 0);

      // 3: continuous streaming at occupancy 1
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         A = code3[i];
         tick();
         chk_state($sformatf("stream%0d", i), 1'b1, onehot3[i], 1);
      end
      in_valid = 1'b0; tick();
      chk_state("stream_end", 1'b0, 4'b0000, 0);

      // 4: random stalls against a queue model
      for (int c = 0; c < 80; c++) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0) ? 1'b0 : 1'b1;
         if (c < 4) out_ready = 1'b0;
         A = 2'($urandom_range(0, 3));
         #1;
         exp_rdy = (model_q.size() < DEPTH);
         exp_y   = (model_q.size() != 0) ? (4'b0001 << model_q[0]) : 4'b0000;
         chk($sformatf("rnd%0d.in_ready", c), {7'd0, in_ready}, {7'd0, exp_rdy});
         chk_state($sformatf("rnd%0d", c), model_q.size() != 0, exp_y, model_q.size());
         do_push = in_valid & exp_rdy;
         do_pop  = out_ready & (model_q.size() != 0);
         if (do_pop)  void'(model_q.pop_front());
         if (do_push) model_q.push_back(A);
         tick();
      end

      // flush while partially filled
      in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1; #1;
      chk("flushA.in_ready", {7'd0, in_ready}, 8'd0);
      tick();
      flush = 1'b0;
      model_q.delete();
      chk_state("flushA", 1'b0, 4'b0000, 0);

      // 5: flush at count=2 with concurrent push and pop
      in_valid = 1'b1; A = 2'd1; tick();
      A = 2'd2; tick();
      chk_state("pre_flush", 1'b1, 4'b0010, 2);
      flush = 1'b1; A = 2'd3; out_ready = 1'b1; #1;
      chk("flushB.in_ready", {7'd0, in_ready}, 8'd0);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk_state("flushB", 1'b0, 4'b0000, 0);
      tick();
      chk_state("flushB_hold", 1'b0, 4'b0000, 0);
      in_valid = 1'b1; A = 2'd2; out_ready = 1'b0; tick();
      in_valid = 1'b0;
      chk_state("post_flush", 1'b1, 4'b0100, 1);

      // asynchronous reset mid-operation
      #1 rst_n = 1'b0; #1;
      chk_state("async_rst", 1'b0, 4'b0000, 0);
      chk("async_rst.in_ready", {7'd0, in_ready}, 8'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("after_rst.in_ready", {7'd0, in_ready}, 8'd1);

`ifdef P_DEC_STICKY_EN
      // 6: sticky accumulation and clear-wins
      in_valid = 1'b1; A = 2'd1; tick();
      A = 2'd3; tick();
      in_valid = 1'b0; out_ready = 1'b1; tick();
      chk("sticky1", {4'd0, sticky}, 8'b0010);
      tick();
      chk("sticky2", {4'd0, sticky}, 8'b1010);
      out_ready = 1'b0; in_valid = 1'b1; A = 2'd0; tick();
      in_valid = 1'b0; out_ready = 1'b1; sticky_clr = 1'b1; tick();
      sticky_clr = 1'b0; out_ready = 1'b0;
      chk("sticky_clr", {4'd0, sticky}, 8'b0000);
      chk_state("sticky_clr", 1'b0, 4'b0000, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
